// File: rtl/axi_id_pool_arbiter_pkg.sv
// Shared types and default sizes for the AXI ID free-pool controller.
package axi_spy_pkg;

    localparam int ID_WIDTH_DEF  = 4;
    localparam int NUM_REQ_DEF   = 4;
    localparam int RET_DEPTH_DEF = 4;

    typedef logic [ID_WIDTH_DEF-1:0] id_t;

    typedef enum logic {
        SEL_ALLOC   = 1'b0,
        SEL_DEALLOC = 1'b1
    } sel_e;

endpackage

// File: rtl/axi_id_pool_arbiter_if.sv
// Requester, ID-return and free-pool signals of the ID pool arbiter.
interface axi_id_pool_arbiter_if
    import axi_spy_pkg::*;
#(
    parameter int ID_WIDTH = ID_WIDTH_DEF,
    parameter int NUM_REQ  = NUM_REQ_DEF
);
    logic [NUM_REQ-1:0]  req_valid;
    logic [NUM_REQ-1:0]  req_ready;
    logic [ID_WIDTH-1:0] req_id;
    logic                b_valid;
    logic [ID_WIDTH-1:0] b_id;
    logic                b_ready;
    logic                r_valid;
    logic [ID_WIDTH-1:0] r_id;
    logic                r_ready;
    logic                pool_alloc_valid;
    logic [ID_WIDTH-1:0] pool_alloc_id;
    logic                pool_alloc_req;
    logic                pool_dealloc_req;
    logic [ID_WIDTH-1:0] pool_dealloc_id;
    logic [ID_WIDTH:0]   outstanding;
    logic                err_double_free;

    modport slave (
        input  req_valid, b_valid, b_id, r_valid, r_id, pool_alloc_valid, pool_alloc_id,
        output req_ready, req_id, b_ready, r_ready, pool_alloc_req, pool_dealloc_req,
               pool_dealloc_id, outstanding, err_double_free
    );

    modport master (
        output req_valid, b_valid, b_id, r_valid, r_id, pool_alloc_valid, pool_alloc_id,
        input  req_ready, req_id, b_ready, r_ready, pool_alloc_req, pool_dealloc_req,
               pool_dealloc_id, outstanding, err_double_free
    );
endinterface

// File: rtl/axi_id_return_fifo.sv
// Two-write / one-read return FIFO; write port 0 lands ahead of port 1.
module axi_id_return_fifo
    import axi_spy_pkg::*;
#(
    parameter int ID_WIDTH = ID_WIDTH_DEF,
    parameter int DEPTH    = RET_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr0_en,
    input  logic [ID_WIDTH-1:0]      wr0_data,
    input  logic                     wr1_en,
    input  logic [ID_WIDTH-1:0]      wr1_data,
    input  logic                     rd_en,
    output logic [ID_WIDTH-1:0]      rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   free_slots
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [ID_WIDTH-1:0] mem_q [DEPTH];
    logic [ID_WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d, wr_ptr_mid;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;

    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign free_slots = PW'(DEPTH) - (wr_ptr_q - rd_ptr_q);
    assign rd_data    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_mid = wr_ptr_q;
        if (wr0_en) begin
            mem_d[wr_ptr_q[AW-1:0]] = wr0_data;
            wr_ptr_mid              = wr_ptr_q + PW'(1);
        end
        wr_ptr_d = wr_ptr_mid;
        if (wr1_en) begin
            mem_d[wr_ptr_mid[AW-1:0]] = wr1_data;
            wr_ptr_d                  = wr_ptr_mid + PW'(1);
        end
        rd_ptr_d = rd_en ? rd_ptr_q + PW'(1) : rd_ptr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end
endmodule

// File: rtl/axi_id_pool_arbiter.sv
// Shares the free-pool alloc port round-robin and serialises alloc/dealloc so
// the pool never sees both in one cycle (it would drop the dealloc).
module axi_id_pool_arbiter
    import axi_spy_pkg::*;
#(
    parameter int ID_WIDTH  = ID_WIDTH_DEF,
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int RET_DEPTH = RET_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    axi_id_pool_arbiter_if.slave  bus
);
    // last_sel     | meaning
    // SEL_ALLOC    | last contention cycle served alloc; next one serves dealloc
    // SEL_DEALLOC  | last contention cycle served dealloc (reset); next one serves alloc
    localparam int RR_W   = $clog2(NUM_REQ);
    localparam int FREE_W = $clog2(RET_DEPTH) + 1;

    function automatic logic [RR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                 input logic [RR_W-1:0]    ptr);
        logic [RR_W-1:0] pick;
        logic            found;
        int              idx;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && valid[idx]) begin
                pick  = RR_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    logic [RR_W-1:0]     rr_ptr_q, rr_ptr_d, winner;
    sel_e                last_sel_q, last_sel_d;
    logic [ID_WIDTH:0]   outstanding_q, outstanding_d;
    logic                err_q, err_d;
    logic                alloc_cand, dealloc_cand, serve_alloc, serve_dealloc;
    logic                ret_ready, b_acc, r_acc, fifo_empty;
    logic [ID_WIDTH-1:0] fifo_head;
    logic [FREE_W-1:0]   free_slots;

    axi_id_return_fifo #(.ID_WIDTH(ID_WIDTH), .DEPTH(RET_DEPTH)) u_ret_fifo (
        .clk        (clk),
        .reset      (reset),
        .wr0_en     (b_acc),
        .wr0_data   (bus.b_id),
        .wr1_en     (r_acc),
        .wr1_data   (bus.r_id),
        .rd_en      (serve_dealloc),
        .rd_data    (fifo_head),
        .empty      (fifo_empty),
        .free_slots (free_slots)
    );

    always_comb begin
        // Two free slots so both return channels can always land together.
        ret_ready     = (free_slots >= FREE_W'(2));
        b_acc         = bus.b_valid && ret_ready;
        r_acc         = bus.r_valid && ret_ready;
        alloc_cand    = !reset && (|bus.req_valid) && bus.pool_alloc_valid;
        dealloc_cand  = !reset && !fifo_empty;
        serve_alloc   = alloc_cand && (!dealloc_cand || last_sel_q == SEL_DEALLOC);
        serve_dealloc = dealloc_cand && !serve_alloc;
        winner        = rr_pick(bus.req_valid, rr_ptr_q);

        last_sel_d    = last_sel_q;
        rr_ptr_d      = rr_ptr_q;
        outstanding_d = outstanding_q;
        if (alloc_cand && dealloc_cand) last_sel_d = serve_alloc ? SEL_ALLOC : SEL_DEALLOC;
        if (serve_alloc) begin
            rr_ptr_d      = (winner == RR_W'(NUM_REQ - 1)) ? '0 : winner + RR_W'(1);
            outstanding_d = outstanding_q + 1'b1;
        end
        if (serve_dealloc) outstanding_d = outstanding_q - 1'b1;
        err_d = err_q || (bus.b_valid && bus.r_valid && ret_ready && bus.b_id == bus.r_id);

        bus.req_ready        = serve_alloc ? (NUM_REQ'(1) << winner) : '0;
        bus.req_id           = bus.pool_alloc_id;
        bus.pool_alloc_req   = serve_alloc;
        bus.pool_dealloc_req = serve_dealloc;
        bus.pool_dealloc_id  = fifo_head;
        bus.b_ready          = ret_ready;
        bus.r_ready          = ret_ready;
        bus.outstanding      = outstanding_q;
        bus.err_double_free  = err_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q      <= '0;
            last_sel_q    <= SEL_DEALLOC;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            last_sel_q    <= last_sel_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
        end
    end

    a_no_dual_req: assert property (@(posedge clk) disable iff (reset)
        !(bus.pool_alloc_req && bus.pool_dealloc_req));
endmodule
